// File: rtl/cache_wb_buffer_pkg.sv
// Shared definitions for the data-cache write-back buffer.
//   - Default geometry of the buffer (depth, address/word width, words per line).
//   - Derived widths: byte-offset bits inside a line and the line-address width.
//   - cache_wb_entry: one buffered victim line at the default geometry.
//   - cache_wb_state_t: drain FSM states.
//   - wb_ofs_w(): offset-width helper for non-default geometries.
package cache_def_pipe_data;

  localparam int unsigned WB_DEPTH      = 4;
  localparam int unsigned WB_ADDR_W     = 32;
  localparam int unsigned WB_WORD_W     = 32;
  localparam int unsigned WB_LINE_WORDS = 4;

  // Byte-offset bits covered by one cache line: word index plus byte-in-word.
  localparam int unsigned WB_OFS_W       = $clog2(WB_LINE_WORDS) + $clog2(WB_WORD_W / 8);
  localparam int unsigned WB_LINE_ADDR_W = WB_ADDR_W - WB_OFS_W;

  typedef struct packed {
    logic                                  valid;
    logic [WB_LINE_ADDR_W-1:0]             line_addr;
    logic [WB_LINE_WORDS*WB_WORD_W-1:0]    data;
  } cache_wb_entry;

  typedef enum logic [0:0] {
    WB_IDLE,
    WB_BURST
  } cache_wb_state_t;

  function automatic int unsigned wb_ofs_w(input int unsigned line_words,
                                           input int unsigned word_w);
    return $clog2(line_words) + $clog2(word_w / 8);
  endfunction

endpackage

// File: rtl/cache_wb_buffer_fifo.sv
// Victim-line storage for the write-back buffer.
//   clk, reset        : clock, asynchronous active-high reset
//   push_valid        : write {push_line_addr, push_data} at the tail (ignored when full)
//   pop               : retire the head entry (ignored when empty)
//   full, count       : occupancy
//   head_line_addr/head_data : oldest entry, feeds the drain side
//   lookup_line_addr  : probe; lookup_hit/lookup_data report the youngest matching entry
module cache_wb_fifo
  import cache_def_pipe_data::*;
#(
  parameter int unsigned DEPTH       = WB_DEPTH,
  parameter int unsigned LINE_ADDR_W = WB_LINE_ADDR_W,
  parameter int unsigned DATA_W      = WB_LINE_WORDS * WB_WORD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [LINE_ADDR_W-1:0]   push_line_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [LINE_ADDR_W-1:0]   head_line_addr,
  output logic [DATA_W-1:0]        head_data,
  input  logic [LINE_ADDR_W-1:0]   lookup_line_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]       valid_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [LINE_ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]      data_q [DEPTH];
  logic                   push_en, pop_en;
  logic [PTR_W-1:0]       lookup_idx;

  // Full is judged on registered occupancy only, so a pop never frees space in the same cycle.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_en = push_valid && !full;
  assign pop_en  = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Push and pop never target the same slot: a pop needs count>0, a push needs count<DEPTH.
      if (push_en) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Payload needs no reset; it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push_en) begin
      addr_q[wr_ptr_q] <= push_line_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  assign count          = count_q;
  assign head_line_addr = addr_q[rd_ptr_q];
  assign head_data      = data_q[rd_ptr_q];

  // Scan oldest to youngest starting at the head; a later match overrides, so the youngest wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lookup_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lookup_idx = rd_ptr_q + PTR_W'(i);
      if (valid_q[lookup_idx] && (addr_q[lookup_idx] == lookup_line_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[lookup_idx];
      end
    end
  end

endmodule

// File: rtl/cache_wb_buffer.sv
// Write-back buffer between the data cache and main memory.
//   clk, reset       : clock, asynchronous active-high reset
//   evict_*          : victim line intake (valid/ready), line address and full line data
//   lookup_*         : combinational probe for lines evicted but not yet written back
//   mem_*            : word-by-word write burst to memory (req/ready)
//   empty, count     : nothing buffered and drain idle / number of valid entries
module cache_wb_buffer
  import cache_def_pipe_data::*;
#(
  parameter int unsigned DEPTH       = WB_DEPTH,
  parameter int unsigned ADDR_W      = WB_ADDR_W,
  parameter int unsigned WORD_W      = WB_WORD_W,
  parameter int unsigned LINE_WORDS  = WB_LINE_WORDS,
  localparam int unsigned OFS_W       = wb_ofs_w(LINE_WORDS, WORD_W),
  localparam int unsigned LINE_ADDR_W = ADDR_W - OFS_W,
  localparam int unsigned DATA_W      = LINE_WORDS * WORD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    evict_valid,
  output logic                    evict_ready,
  input  logic [LINE_ADDR_W-1:0]  evict_line_addr,
  input  logic [DATA_W-1:0]       evict_data,
  input  logic [LINE_ADDR_W-1:0]  lookup_line_addr,
  output logic                    lookup_hit,
  output logic [DATA_W-1:0]       lookup_data,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORD_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned BYTE_W = OFS_W - BEAT_W;

  cache_wb_state_t                      state_q, state_d;
  logic [BEAT_W-1:0]                    beat_q, beat_d;
  logic                                 full;
  logic                                 pop;
  logic [LINE_ADDR_W-1:0]               head_line_addr;
  logic [DATA_W-1:0]                    head_data;
  logic [LINE_WORDS-1:0][WORD_W-1:0]    head_words;

  cache_wb_fifo #(
    .DEPTH       (DEPTH),
    .LINE_ADDR_W (LINE_ADDR_W),
    .DATA_W      (DATA_W)
  ) u_fifo (
    .clk              (clk),
    .reset            (reset),
    .push_valid       (evict_valid),
    .push_line_addr   (evict_line_addr),
    .push_data        (evict_data),
    .pop              (pop),
    .full             (full),
    .count            (count),
    .head_line_addr   (head_line_addr),
    .head_data        (head_data),
    .lookup_line_addr (lookup_line_addr),
    .lookup_hit       (lookup_hit),
    .lookup_data      (lookup_data)
  );

  assign evict_ready = !full;
  assign head_words  = head_data;

  // Returning to IDLE after each line costs one bubble but keeps the FSM trivially simple.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (count != '0) begin
          state_d = WB_BURST;
          beat_d  = '0;
        end
      end
      WB_BURST: begin
        if (mem_ready) begin
          if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
            pop     = 1'b1;
            beat_d  = '0;
            state_d = WB_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = WB_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WB_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Memory side is a pure function of registered state, never of mem_ready.
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == WB_BURST) begin
      mem_req   = 1'b1;
      mem_addr  = {head_line_addr, beat_q, {BYTE_W{1'b0}}};
      mem_wdata = head_words[beat_q];
    end
  end

  assign empty = (count == '0) && (state_q == WB_IDLE);

endmodule

// File: tb/tb_cache_wb_buffer.sv
module tb_cache_wb_buffer;

  localparam int DEPTH = 4;
  localparam int LW    = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         evict_valid;
  logic         evict_ready;
  logic [27:0]  evict_line_addr;
  logic [127:0] evict_data;
  logic [27:0]  lookup_line_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic         empty;
  logic [2:0]   count;

  int checks   = 0;
  int failures = 0;

  cache_wb_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .evict_valid      (evict_valid),
    .evict_ready      (evict_ready),
    .evict_line_addr  (evict_line_addr),
    .evict_data       (evict_data),
    .lookup_line_addr (lookup_line_addr),
    .lookup_hit       (lookup_hit),
    .lookup_data      (lookup_data),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ready        (mem_ready),
    .empty            (empty),
    .count            (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk(input logic [15:0] s);
    return {s, 16'd3, s, 16'd2, s, 16'd1, s, 16'd0};
  endfunction

  // ---------------- behavioural model: queue of lines plus drain progress ----------------
  logic [27:0]  mq_addr[$];
  logic [127:0] mq_data[$];
  bit           m_busy;
  int           m_beat;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq_addr.delete();
      mq_data.delete();
      m_busy = 0;
      m_beat = 0;
    end else begin
      int sz;
      bit do_push;
      sz      = mq_addr.size();
      do_push = evict_valid && (sz < DEPTH);
      if (m_busy) begin
        if (mem_ready) begin
          if (m_beat == LW - 1) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
            m_busy = 0;
            m_beat = 0;
          end else begin
            m_beat++;
          end
        end
      end else if (sz != 0) begin
        m_busy = 1;
        m_beat = 0;
      end
      if (do_push) begin
        mq_addr.push_back(evict_line_addr);
        mq_data.push_back(evict_data);
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    logic [31:0]  e_addr, e_wdata;
    logic [127:0] e_ldata, line;
    logic         e_hit;
    e_addr  = '0;
    e_wdata = '0;
    if (m_busy) begin
      e_addr  = (32'(mq_addr[0]) << 4) + 32'(m_beat * 4);
      line    = mq_data[0];
      e_wdata = line[m_beat*32 +: 32];
    end
    e_hit   = 1'b0;
    e_ldata = '0;
    for (int i = mq_addr.size() - 1; i >= 0; i--) begin
      if (!e_hit && mq_addr[i] == lookup_line_addr) begin
        e_hit   = 1'b1;
        e_ldata = mq_data[i];
      end
    end
    chk("cmp_mem_req", 128'(mem_req), 128'(m_busy));
    chk("cmp_mem_addr", 128'(mem_addr), 128'(e_addr));
    chk("cmp_mem_wdata", 128'(mem_wdata), 128'(e_wdata));
    chk("cmp_count", 128'(count), 128'(mq_addr.size()));
    chk("cmp_evict_ready", 128'(evict_ready), 128'(mq_addr.size() < DEPTH));
    chk("cmp_empty", 128'(empty), 128'(mq_addr.size() == 0 && !m_busy));
    chk("cmp_lookup_hit", 128'(lookup_hit), 128'(e_hit));
    chk("cmp_lookup_data", lookup_data, e_ldata);
  end

  // Log of accepted beats (mem_ready is stable around the falling edge).
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  always @(negedge clk) begin
    if (!reset && mem_req && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty;
    int n = 0;
    while (!empty && n < 200) begin
      tick();
      n++;
    end
    chk("drain_done", 128'(empty), 128'(1));
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    reset            = 1'b1;
    evict_valid      = 1'b0;
    evict_line_addr  = '0;
    evict_data       = '0;
    lookup_line_addr = 28'h0000010;
    mem_ready        = 1'b0;
    #3;
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
    chk("rst_evict_ready", 128'(evict_ready), 128'(1));
    chk("rst_lookup_hit", 128'(lookup_hit), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_count", 128'(count), 128'(0));
    tick();
    tick();
    reset = 1'b0;

    // ---- single line ----
    mem_ready       = 1'b1;
    evict_valid     = 1'b1;
    evict_line_addr = 28'h0000010;
    evict_data      = {32'h44, 32'h33, 32'h22, 32'h11};
    tick();
    evict_valid = 1'b0;
    chk("t1_idle_req", 128'(mem_req), 128'(0));
    chk("t1_hit_while_idle", 128'(lookup_hit), 128'(1));
    tick();
    chk("t1_b0_addr", 128'(mem_addr), 128'h100);
    chk("t1_b0_data", 128'(mem_wdata), 128'h11);
    tick();
    chk("t1_b1_addr", 128'(mem_addr), 128'h104);
    chk("t1_b1_data", 128'(mem_wdata), 128'h22);
    tick();
    chk("t1_b2_addr", 128'(mem_addr), 128'h108);
    chk("t1_b2_data", 128'(mem_wdata), 128'h33);
    tick();
    chk("t1_b3_addr", 128'(mem_addr), 128'h10C);
    chk("t1_b3_data", 128'(mem_wdata), 128'h44);
    tick();
    chk("t1_empty_after", 128'(empty), 128'(1));
    chk("t1_req_after", 128'(mem_req), 128'(0));

    // ---- backpressure on beat 2 ----
    clear_log();
    evict_valid = 1'b1;
    tick();
    evict_valid = 1'b0;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t2_hold_req", 128'(mem_req), 128'(1));
      chk("t2_hold_addr", 128'(mem_addr), 128'h108);
      chk("t2_hold_data", 128'(mem_wdata), 128'h33);
      tick();
    end
    mem_ready = 1'b1;
    wait_empty();
    chk("t2_beats", 128'(log_addr.size()), 128'(4));
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("t2_log_addr", 128'(log_addr[i]), 128'(32'h100 + 32'(i * 4)));
      chk("t2_log_data", 128'(log_data[i]), 128'(32'h11 * 32'(i + 1)));
    end

    // ---- full ----
    clear_log();
    mem_ready   = 1'b0;
    evict_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      evict_line_addr = 28'h50 + 28'(i);
      evict_data      = mk(16'(i));
      tick();
      if (i == 3) chk("t3_ready_low_after4", 128'(evict_ready), 128'(0));
    end
    evict_valid = 1'b0;
    chk("t3_count4", 128'(count), 128'(4));
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t3_ready_before_pop", 128'(evict_ready), 128'(0));
    tick();
    chk("t3_ready_after_pop", 128'(evict_ready), 128'(1));
    chk("t3_count3", 128'(count), 128'(3));
    wait_empty();
    chk("t3_beats", 128'(log_addr.size()), 128'(16));
    if (log_addr.size() == 16) begin
      chk("t3_last_line_addr", 128'(log_addr[12]), 128'h530);
      chk("t3_last_beat_addr", 128'(log_addr[15]), 128'h53C);
      chk("t3_last_beat_data", 128'(log_data[15]), 128'h00030003);
    end

    // ---- lookup forwarding ----
    clear_log();
    mem_ready   = 1'b0;
    evict_valid = 1'b1;
    evict_line_addr = 28'h20; evict_data = mk(16'hD1); tick();
    evict_line_addr = 28'h20; evict_data = mk(16'hD2); tick();
    evict_line_addr = 28'h30; evict_data = mk(16'hD3); tick();
    evict_valid = 1'b0;
    lookup_line_addr = 28'h20;
    #1;
    chk("t4_hit_a", 128'(lookup_hit), 128'(1));
    chk("t4_data_a", lookup_data, {32'h00D20003, 32'h00D20002, 32'h00D20001, 32'h00D20000});
    lookup_line_addr = 28'h40;
    #1;
    chk("t4_hit_miss", 128'(lookup_hit), 128'(0));
    chk("t4_data_miss", lookup_data, 128'(0));
    lookup_line_addr = 28'h20;
    mem_ready = 1'b1;
    begin
      int n = 0;
      while (count != 3'd1 && n < 40) begin
        tick();
        n++;
      end
    end
    chk("t4_count1", 128'(count), 128'(1));
    chk("t4_hit_gone", 128'(lookup_hit), 128'(0));
    chk("t4_data_gone", lookup_data, 128'(0));
    lookup_line_addr = 28'h30;
    #1;
    chk("t4_hit_b", 128'(lookup_hit), 128'(1));
    chk("t4_data_b", lookup_data, mk(16'hD3));
    wait_empty();

    // ---- push coinciding with last-beat pop ----
    clear_log();
    mem_ready   = 1'b1;
    evict_valid = 1'b1;
    evict_line_addr = 28'h60; evict_data = mk(16'h60); tick();
    evict_line_addr = 28'h61; evict_data = mk(16'h61); tick();
    evict_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t5_count_before", 128'(count), 128'(2));
    chk("t5_last_beat", 128'(mem_addr), 128'h60C);
    evict_valid = 1'b1;
    evict_line_addr = 28'h62; evict_data = mk(16'h62);
    tick();
    evict_valid = 1'b0;
    chk("t5_count_after", 128'(count), 128'(2));
    wait_empty();
    chk("t5_beats", 128'(log_addr.size()), 128'(12));
    if (log_addr.size() == 12) begin
      chk("t5_order0", 128'(log_addr[0]), 128'h600);
      chk("t5_order1", 128'(log_addr[4]), 128'h610);
      chk("t5_order2", 128'(log_addr[8]), 128'h620);
      chk("t5_data2", 128'(log_data[11]), 128'h00620003);
    end

    // ---- reset mid-burst ----
    mem_ready   = 1'b0;
    evict_valid = 1'b1;
    evict_line_addr = 28'h70; evict_data = mk(16'h70); tick();
    evict_line_addr = 28'h71; evict_data = mk(16'h71); tick();
    evict_line_addr = 28'h72; evict_data = mk(16'h72); tick();
    evict_valid = 1'b0;
    mem_ready   = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t6_in_beat1", 128'(mem_addr), 128'h704);
    clear_log();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_req_drop", 128'(mem_req), 128'(0));
    chk("t6_count0", 128'(count), 128'(0));
    chk("t6_empty", 128'(empty), 128'(1));
    tick();
    reset     = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_no_beats", 128'(log_addr.size()), 128'(0));
    chk("t6_req_idle", 128'(mem_req), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_wb_buffer.md
Name: cache_wb_buffer

Overview:
- Write-back buffer on the memory side of the 4-way set-associative data cache. It takes dirty victim lines evicted by the non-read (write/refill) pipeline and buffers them in a small FIFO.
- It drains each line to main memory as a word-by-word burst under a req/ready handshake.
- It provides an associative lookup so the read path can forward a line that has been evicted but not yet written back.

Parameters:
- DEPTH, 4, number of buffered victim lines (power of two, ≥2)
- ADDR_W, 32, byte address width
- WORD_W, 32, memory beat width
- LINE_WORDS, 4, words per cache line (power of two)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- evict_valid  in  1  victim line presented
- evict_ready  out  1  buffer can accept; equals !full from registered state only
- evict_line_addr  in  ADDR_W-OFS_W  line address (OFS_W = log2(LINE_WORDS)+log2(WORD_W/8))
- evict_data  in  LINE_WORDS*WORD_W  line data; word i = bits[i*WORD_W +: WORD_W]
- lookup_line_addr  in  ADDR_W-OFS_W  read-path probe address
- lookup_hit  out  1  probe matches a valid entry
- lookup_data  out  LINE_WORDS*WORD_W  data of youngest matching entry; 0 when no hit
- mem_req  out  1  write beat valid
- mem_addr  out  ADDR_W  byte address of beat: {line_addr, beat, byte-offset zeros}
- mem_wdata  out  WORD_W  beat data
- mem_ready  in  1  memory accepts current beat
- empty  out  1  no valid entries and drain FSM idle
- count  out  log2(DEPTH)+1  valid entries (includes entry being drained)

Behaviour:
- Reset (async): all entries invalid, wr/rd pointers 0, FSM IDLE, beat 0.
  - Output reset values: mem_req=0, mem_addr=0, mem_wdata=0, evict_ready=1, lookup_hit=0, empty=1, count=0.
- Reset mid-burst: the burst is abandoned, all buffered lines are dropped, and mem_req falls asynchronously.
- Push: on a clk edge with evict_valid && evict_ready, the entry {line_addr, data} is written at wr_ptr, wr_ptr advances (wraps modulo DEPTH), and count increments.
- Full (count==DEPTH): evict_ready=0. A pop in the same cycle does not admit a push; space is visible the next cycle.
- Drain FSM:
  - IDLE: if count≠0, go to BURST with beat=0; otherwise stay in IDLE.
  - BURST: mem_req=1 and mem_addr/mem_wdata are driven from the head entry and beat. Address and data stay stable while mem_ready=0.
    - On mem_ready with beat<LINE_WORDS-1: beat++.
    - On mem_ready with beat==LINE_WORDS-1: pop the head (rd_ptr++, count--), beat=0, go to IDLE. This gives one idle bubble between lines.
  - mem_req must never depend combinationally on mem_ready.
  - Minimum latency: a push at edge N gives mem_req=1 from edge N+1 (IDLE→BURST), with the first beat in cycle N+1.
- Simultaneous push and pop (not full): count is unchanged, and both pointers advance.
- Lookup: combinational compare against every valid entry, including the head being drained.
  - With multiple matches, the youngest entry (closest to wr_ptr) wins.
  - An entry stays visible until its last beat is accepted. In the pop cycle it still hits; from the next cycle it does not.
  - A push in the same cycle is not visible until after the edge.
- Duplicate line addresses are permitted. Entries are not coalesced, and both drain in FIFO order.
- empty = (count==0) && FSM==IDLE.

Decomposition:
- Add to cache_def_pipe_data:
  - typedef cache_wb_entry (packed struct: valid, line_addr, data)
  - enum cache_wb_state_t {WB_IDLE, WB_BURST}
  - localparams for OFS_W and the line address width
- Sub-module cache_wb_fifo: entry storage, pointers, count, full/empty, and the parallel youngest-match lookup. cache_wb_buffer adds the drain FSM, beat counter and memory interface.

Test Plan:
- Single line: push line_addr 0x0000010, data words {0x11,0x22,0x33,0x44}, mem_ready=1 constantly. Required: four beats at mem_addr 0x100, 0x104, 0x108, 0x10C with wdata 0x11..0x44, then empty=1 one cycle after the last beat.
- Backpressure: same push, with mem_ready low for 3 cycles on beat 2. Required: mem_addr=0x108 and wdata=0x33 held stable with mem_req=1 for those 3 cycles, and no beat is skipped or repeated.
- Full: push 5 lines with mem_ready=0. Required: evict_ready=0 after the 4th push, the 5th is not accepted, and count=4. Then raise mem_ready. Required: evict_ready rises the cycle after the first pop.
- Lookup forwarding: push A=0x20 (data D1), then A=0x20 (data D2), then B=0x30. Required: probe 0x20 gives hit with D2, probe 0x40 gives hit=0 with data 0. After both A lines drain, probe 0x20 gives hit=0.
- Push/pop same cycle: count=2, push coincides with the last-beat accept. Required: count stays 2 and FIFO order is preserved on the memory side.
- Reset mid-burst: assert reset during beat 1 of a 3-entry buffer. Required: mem_req=0 immediately, count=0, empty=1, and no further beats after deassert.
